// File: rtl/fabric_cfg_defs_pkg.sv
// Fabric configuration address map and loader state encoding, shared with the config responder.
// The RD/CHK states exist only when LOADER_READBACK_VERIFY_EN is defined.
package fabric_cfg_defs_pkg;

    localparam logic [31:0] FABRIC_CFG_BASE    = 32'h3000_0000;
    localparam int unsigned FABRIC_COL_STRIDE  = 4;
    localparam int unsigned FABRIC_NUM_COLS    = 3;
    localparam logic [31:0] FABRIC_CTRL_OFFSET = 32'h10;
    localparam logic [31:0] FABRIC_COMMIT_WORD = 32'h1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BEAT   = 3'd1,
        S_WR     = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
`ifdef LOADER_READBACK_VERIFY_EN
        ,
        S_RD     = 3'd6,
        S_CHK    = 3'd7
`endif
    } loader_state_t;

    function automatic logic [31:0] column_addr(input logic [31:0] base,
                                                input logic [1:0]  col,
                                                input int unsigned stride);
        return base + {30'd0, col} * stride;
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Counts cycles a Wishbone strobe has been held without ack; pulses timeout at TIMEOUT_CYCLES.
// The count saturates at the limit so the timeout stays asserted until cleared.
module wb_ack_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = enable && (count == LIMIT);

endmodule

// File: rtl/wb_bitstream_loader.sv
// Wishbone initiator streaming tagged config words into the fabric responder, then a commit write.
// Define LOADER_READBACK_VERIFY_EN to read back and compare every data word after it is written.
module wb_bitstream_loader
    import fabric_cfg_defs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = FABRIC_CFG_BASE,
    parameter int unsigned COL_STRIDE     = FABRIC_COL_STRIDE,
    parameter int unsigned NUM_COLS       = FABRIC_NUM_COLS,
    parameter logic [31:0] CTRL_OFFSET    = FABRIC_CTRL_OFFSET,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic [1:0]       s_col,
    input  logic             s_last,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_addr_o,
    output logic [31:0]      wbm_data_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_data_i
);

    loader_state_t state;
    logic [31:0]   word_q;
    logic          last_q;
    logic          ack_seen;
    logic          timeout;
    logic          col_bad;
    logic [31:0]   col_addr;

`ifdef LOADER_READBACK_VERIFY_EN
    logic [31:0]   rd_q;
`else
    logic          unused_rdata;
    assign unused_rdata = ^wbm_data_i;
`endif

    // An ack outside an active strobe is a stray and must not advance the FSM.
    assign ack_seen = wbm_ack_i && wbm_cyc_o && wbm_stb_o;
    assign col_bad  = {30'd0, s_col} >= NUM_COLS;
    assign col_addr = column_addr(BASE_ADDR, s_col, COL_STRIDE);

    // Every transaction starts with stb low for at least one cycle, which restarts the count.
    wb_ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (!wbm_stb_o),
        .enable (wbm_stb_o),
        .timeout(timeout)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            s_ready    <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_addr_o <= '0;
            wbm_data_o <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
`ifdef LOADER_READBACK_VERIFY_EN
            rd_q       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_BEAT;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        s_ready    <= 1'b1;
                    end
                end

                S_BEAT: begin
                    if (s_valid && s_ready) begin
                        s_ready <= 1'b0;
                        word_q  <= s_data;
                        last_q  <= s_last;
                        if (col_bad) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state      <= S_WR;
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            wbm_we_o   <= 1'b1;
                            wbm_sel_o  <= 4'hF;
                            wbm_addr_o <= col_addr;
                            wbm_data_o <= s_data;
                        end
                    end
                end

                S_WR: begin
                    if (ack_seen) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        if (word_count != '1) word_count <= word_count + CNT_W'(1);
`ifdef LOADER_READBACK_VERIFY_EN
                        state <= S_RD;
`else
                        if (last_q) begin
                            state <= S_COMMIT;
                        end else begin
                            state   <= S_BEAT;
                            s_ready <= 1'b1;
                        end
`endif
                    end else if (timeout) begin
                        state     <= S_ERROR;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end
                end

`ifdef LOADER_READBACK_VERIFY_EN
                S_RD: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'hF;
                    end else if (ack_seen) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rd_q      <= wbm_data_i;
                        state     <= S_CHK;
                    end else if (timeout) begin
                        state     <= S_ERROR;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                    end
                end

                S_CHK: begin
                    if (rd_q != word_q) begin
                        state <= S_ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (last_q) begin
                        state <= S_COMMIT;
                    end else begin
                        state   <= S_BEAT;
                        s_ready <= 1'b1;
                    end
                end
`endif

                S_COMMIT: begin
                    // First cycle leaves cyc low so the commit is a separate bus cycle.
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        wbm_we_o   <= 1'b1;
                        wbm_sel_o  <= 4'hF;
                        wbm_addr_o <= BASE_ADDR + CTRL_OFFSET;
                        wbm_data_o <= FABRIC_COMMIT_WORD;
                    end else if (ack_seen) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end else if (timeout) begin
                        state     <= S_ERROR;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bitstream_loader.sv
// Scoreboard bench for wb_bitstream_loader: expected bus operations are queued as beats are driven
// and checked when the modelled responder acks them. CNT_W is reduced to exercise saturation.
`timescale 1ns/1ps
module tb_wb_bitstream_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CTRL = 32'h3000_0010;
    localparam int          TMO  = 64;
    localparam int          CW   = 2;
`ifdef LOADER_READBACK_VERIFY_EN
    localparam int          BEAT_SPACING = 5;
`else
    localparam int          BEAT_SPACING = 2;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_op_t;

    logic          clk = 1'b0;
    logic          wb_rst_i, start, busy, done, err;
    logic [CW-1:0] word_count;
    logic          s_valid, s_ready, s_last;
    logic [31:0]   s_data;
    logic [1:0]    s_col;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_addr_o, wbm_data_o, wbm_data_i;

    always #5 clk = ~clk;

    wb_bitstream_loader #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_count(word_count),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_col     (s_col),
        .s_last    (s_last),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_addr_o(wbm_addr_o),
        .wbm_data_o(wbm_data_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_data_i(wbm_data_i)
    );

    int          total = 0;
    int          bad   = 0;
    bus_op_t     sb[$];
    int          commits    = 0;
    int          ack_delay  = 1;
    bit          ack_en     = 1'b1;
    bit          rd_corrupt = 1'b0;
    logic [31:0] last_wdata = '0;
    int          cycle      = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Responder model: acks ack_delay cycles after stb is seen, checks each op against the scoreboard.
    initial begin : responder
        int      wait_cnt;
        bus_op_t exp_op;
        wait_cnt   = 0;
        wbm_ack_i  = 1'b0;
        wbm_data_i = '0;
        forever begin
            @(negedge clk);
            if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (wbm_cyc_o && wbm_stb_o && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    wbm_ack_i = 1'b1;
                    wait_cnt  = 0;
                    if (wbm_we_o) last_wdata = wbm_data_o;
                    else wbm_data_i = rd_corrupt ? 32'hDEAD_BEEF : last_wdata;
                    if (wbm_we_o && wbm_addr_o == CTRL) commits++;
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h, required no bus op",
                                 wbm_we_o, wbm_addr_o, wbm_data_o);
                    end else begin
                        exp_op = sb.pop_front();
                        if (wbm_we_o !== exp_op.we || wbm_addr_o !== exp_op.addr || wbm_sel_o !== 4'hF ||
                            (exp_op.we && wbm_data_o !== exp_op.data)) begin
                            bad++;
                            $display("FAIL bus_op: got we=%0b addr=%h data=%h sel=%h, required we=%0b addr=%h data=%h sel=f",
                                     wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o, exp_op.we, exp_op.addr, exp_op.data);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back('{we: 1'b1, addr: addr, data: data});
`ifdef LOADER_READBACK_VERIFY_EN
        sb.push_back('{we: 1'b0, addr: addr, data: data});
`endif
    endtask

    task automatic push_commit();
        sb.push_back('{we: 1'b1, addr: CTRL, data: 32'h1});
    endtask

    // Called at a negedge; returns at the negedge right after the beat was accepted.
    task automatic send_beat(input logic [1:0] col, input logic [31:0] data, input bit last,
                             input bit expect_bus, output int acc_cycle);
        int n = 0;
        if (expect_bus) begin
            push_write(BASE + 32'(col) * 32'd4, data);
            if (last) push_commit();
        end
        s_valid = 1'b1;
        s_col   = col;
        s_data  = data;
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL beat_accept: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(negedge clk);
        acc_cycle = cycle;
        s_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || err) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(done || err)) begin
            bad++;
            $display("FAIL %s_end: done=%0b err=%0b after %0d cycles, required done or err", name, done, err, n);
        end
    endtask

    task automatic test_reset();
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b required 000", {busy, done, err}); end
        total++; if (word_count !== '0) begin bad++; $display("FAIL reset_count: got %0d required 0", word_count); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", s_ready); end
        total++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b required 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        total++; if (wbm_sel_o !== 4'h0) begin bad++; $display("FAIL reset_sel: got %h required 0", wbm_sel_o); end
        total++; if (wbm_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h required 0", wbm_addr_o); end
        total++; if (wbm_data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h required 0", wbm_data_o); end
    endtask

    task automatic test_three_beats();
        int c0 = commits;
        int t;
        ack_delay = 1;
        pulse_start();
        total++; if (busy !== 1'b1 || s_ready !== 1'b1) begin bad++; $display("FAIL start_busy: busy=%b s_ready=%b required 1 1", busy, s_ready); end
        send_beat(2'd0, 32'hA5A5_0001, 1'b0, 1'b1, t);
        send_beat(2'd1, 32'hA5A5_0002, 1'b0, 1'b1, t);
        send_beat(2'd2, 32'hA5A5_0003, 1'b1, 1'b1, t);
        wait_end("three");
        total++; if ({done, err, busy} !== 3'b100) begin bad++; $display("FAIL three_status: done/err/busy got %b required 100", {done, err, busy}); end
        total++; if (word_count !== CW'(3)) begin bad++; $display("FAIL three_count: got %0d required 3", word_count); end
        total++; if (commits !== c0 + 1) begin bad++; $display("FAIL three_commit: got %0d commits required %0d", commits, c0 + 1); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL three_sb: %0d ops pending required 0", sb.size()); end
    endtask

    task automatic test_stall();
        int t;
        int n = 0;
        int viol = 0;
        pulse_start();
        send_beat(2'd0, 32'h0000_1111, 1'b0, 1'b1, t);
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            if (s_ready !== 1'b1 || wbm_cyc_o !== 1'b0) viol++;
            @(negedge clk);
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL stall_idle: %0d cycles with s_ready!=1 or cyc!=0, required 0", viol); end
        send_beat(2'd1, 32'h0000_2222, 1'b0, 1'b1, t);
        send_beat(2'd2, 32'h0000_3333, 1'b1, 1'b1, t);
        wait_end("stall");
        total++; if (done !== 1'b1 || word_count !== CW'(3)) begin bad++; $display("FAIL stall_done: done=%b count=%0d required 1 3", done, word_count); end
    endtask

    task automatic test_bad_col();
        int t;
        int cyc_seen = 0;
        int c0;
        pulse_start();
        send_beat(2'd1, 32'h0000_0011, 1'b0, 1'b1, t);
        c0 = commits;
        send_beat(2'd3, 32'h0000_0099, 1'b1, 1'b0, t);
        for (int i = 0; i < 6; i++) begin
            if (wbm_cyc_o) cyc_seen++;
            @(negedge clk);
        end
        total++; if (cyc_seen !== 0) begin bad++; $display("FAIL badcol_bus: cyc high %0d cycles required 0", cyc_seen); end
        total++; if ({err, done, busy} !== 3'b100) begin bad++; $display("FAIL badcol_status: err/done/busy got %b required 100", {err, done, busy}); end
        total++; if (word_count !== CW'(1)) begin bad++; $display("FAIL badcol_count: got %0d required 1", word_count); end
        total++; if (commits !== c0) begin bad++; $display("FAIL badcol_commit: got %0d commits required %0d", commits, c0); end
    endtask

    task automatic test_timeout();
        int t;
        int n = 0;
        int m = 0;
        int c0 = commits;
        ack_en = 1'b0;
        pulse_start();
        send_beat(2'd1, 32'h0000_0077, 1'b1, 1'b0, t);
        while (!wbm_stb_o && n < 10) begin @(negedge clk); n++; end
        while (wbm_cyc_o && m < TMO + 10) begin @(negedge clk); m++; end
        total++; if (m !== TMO + 1) begin bad++; $display("FAIL timeout_len: cyc dropped after %0d cycles required %0d", m, TMO + 1); end
        total++; if ({err, done, busy} !== 3'b100) begin bad++; $display("FAIL timeout_status: err/done/busy got %b required 100", {err, done, busy}); end
        repeat (4) @(negedge clk);
        total++; if (commits !== c0 || wbm_cyc_o !== 1'b0) begin bad++; $display("FAIL timeout_commit: commits=%0d cyc=%b required %0d 0", commits, wbm_cyc_o, c0); end
        ack_en = 1'b1;
        pulse_start();
        total++; if ({err, done, word_count} !== {2'b00, CW'(0)}) begin bad++; $display("FAIL restart_clear: err=%b done=%b count=%0d required 0 0 0", err, done, word_count); end
        send_beat(2'd2, 32'hCAFE_0001, 1'b0, 1'b1, t);
        send_beat(2'd0, 32'hCAFE_0002, 1'b1, 1'b1, t);
        wait_end("restart");
        total++; if (done !== 1'b1 || err !== 1'b0 || word_count !== CW'(2)) begin bad++; $display("FAIL restart_done: done=%b err=%b count=%0d required 1 0 2", done, err, word_count); end
    endtask

    task automatic test_reset_mid();
        int t;
        int viol = 0;
        int c0 = commits;
        ack_en = 1'b0;
        pulse_start();
        send_beat(2'd2, 32'h0000_0055, 1'b1, 1'b0, t);
        total++; if (wbm_cyc_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre: cyc=%b required 1", wbm_cyc_o); end
        wb_rst_i = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, err, s_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_data_o, word_count} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: cyc=%b stb=%b addr=%h busy=%b count=%0d required all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_addr_o, busy, word_count);
        end
        wb_rst_i = 1'b0;
        ack_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbm_cyc_o !== 1'b0 || busy !== 1'b0) viol++;
        end
        total++; if (viol !== 0 || commits !== c0) begin bad++; $display("FAIL rstmid_quiet: %0d active cycles, commits=%0d required 0 and %0d", viol, commits, c0); end
    endtask

    task automatic test_back_to_back();
        int acc[4];
        ack_delay = 0;
        pulse_start();
        send_beat(2'd0, 32'h0BB0_0000, 1'b0, 1'b1, acc[0]);
        send_beat(2'd1, 32'h0BB0_0001, 1'b0, 1'b1, acc[1]);
        send_beat(2'd2, 32'h0BB0_0002, 1'b0, 1'b1, acc[2]);
        send_beat(2'd0, 32'h0BB0_0003, 1'b1, 1'b1, acc[3]);
        for (int i = 1; i < 4; i++) begin
            total++;
            if (acc[i] - acc[i-1] !== BEAT_SPACING) begin
                bad++;
                $display("FAIL b2b_spacing%0d: got %0d cycles required %0d", i, acc[i] - acc[i-1], BEAT_SPACING);
            end
        end
        wait_end("b2b");
        total++; if (done !== 1'b1 || word_count !== CW'(3)) begin bad++; $display("FAIL b2b_saturate: done=%b count=%0d required 1 3", done, word_count); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL b2b_sb: %0d ops pending required 0", sb.size()); end
        ack_delay = 1;
    endtask

`ifdef LOADER_READBACK_VERIFY_EN
    task automatic test_readback();
        int t;
        int c0 = commits;
        rd_corrupt = 1'b1;
        pulse_start();
        push_write(BASE, 32'h1234_5678);
        send_beat(2'd0, 32'h1234_5678, 1'b1, 1'b0, t);
        wait_end("readback");
        repeat (4) @(negedge clk);
        total++; if ({err, done} !== 2'b10) begin bad++; $display("FAIL readback_status: err/done got %b required 10", {err, done}); end
        total++; if (commits !== c0 || sb.size() !== 0) begin bad++; $display("FAIL readback_ops: commits=%0d pending=%0d required %0d 0", commits, sb.size(), c0); end
        rd_corrupt = 1'b0;
    endtask
`endif

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_rst_i = 1'b1;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_col    = '0;
        s_last   = 1'b0;
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        test_reset();
        test_three_beats();
        test_stall();
        test_bad_col();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef LOADER_READBACK_VERIFY_EN
        test_readback();
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_bitstream_loader.md
Name: wb_bitstream_loader

Overview:
- Wishbone initiator that streams a configuration bitstream into the fabric's Wishbone configuration responder (base 0x3000_0000).
- Accepts 32-bit config words with a column tag over a valid/ready stream from the management-side source (DMA, FIFO or ROM walker).
- Issues one single-beat Wishbone write per word, then a commit write to the control register.
- Reports busy/done/error; replaces software-driven programming on the same bus.

Parameters:
- BASE_ADDR, 32'h3000_0000, responder base address
- COL_STRIDE, 4, byte stride between per-column data registers
- NUM_COLS, 3, valid column tags 0..NUM_COLS-1
- CTRL_OFFSET, 32'h10, byte offset of the commit/control register
- TIMEOUT_CYCLES, 64, cycles to wait for ack before aborting
- CNT_W, 16, width of the word counter

Ports:
- wb_clk_i  in  1  fabric/bus clock
- wb_rst_i  in  1  reset; synchronous, active-high
- start  in  1  begin a load; pulse
- busy  out  1  load in progress
- done  out  1  load completed; sticky until next start
- err  out  1  load aborted; sticky until next start
- word_count  out  CNT_W  data words acknowledged this load, saturating
- s_valid  in  1  stream beat valid
- s_ready  out  1  loader accepts beat
- s_data  in  32  config word
- s_col  in  2  target column
- s_last  in  1  final beat of bitstream
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte select
- wbm_addr_o  out  32  address
- wbm_data_o  out  32  write data
- wbm_ack_i  in  1  responder ack
- wbm_data_i  in  32  read data (used only with the optional feature)

Behaviour:
- All outputs registered. Reset: state IDLE; all outputs 0, including word_count, s_ready, cyc/stb/we, sel, addr and data.
- States: IDLE, BEAT, WR, COMMIT, DONE, ERROR (plus RD and CHK with the optional feature).
- IDLE/DONE/ERROR + start: clear done, err and word_count; go to BEAT. start in any other state is ignored.
- BEAT: s_ready=1. On s_valid&s_ready, latch data, col and last; s_ready drops next cycle.
- BEAT with s_col >= NUM_COLS: no bus access; err=1; go to ERROR.
- Otherwise go to WR. In the following cycle drive:
  - cyc=stb=we=1, sel=4'hF
  - addr = BASE_ADDR + s_col*COL_STRIDE
  - data = latched word
- WR: hold all bus signals until ack. ack is sampled at the clock edge; cyc/stb deassert the cycle after ack is seen. Minimum 2 cycles per word; ack on the first stb cycle is legal.
- On ack, word_count increments (saturates at all-ones).
  - latched last=0: go to BEAT.
  - latched last=1: go to COMMIT.
- COMMIT: write addr = BASE_ADDR + CTRL_OFFSET, data = 32'h1, sel=4'hF. On ack go to DONE: done=1, busy=0.
- busy=1 in BEAT, WR, COMMIT (and RD, CHK).
- Timeout: per-transaction counter cleared when stb rises. If TIMEOUT_CYCLES cycles elapse without ack:
  - drop cyc/stb next cycle
  - err=1, go to ERROR
  - no commit is issued
- ack while cyc=0: ignored.
- ack arriving in the same cycle the timeout hits: ack wins.
- Reset mid-transaction: cyc/stb are 0 after the reset edge; no commit is issued.

Optional Feature:
- Macro: LOADER_READBACK_VERIFY_EN.
- Defined: after each data-word ack, go to RD and issue a read (we=0) to the same address. On ack, compare wbm_data_i to the latched word in CHK.
  - Mismatch: err=1, go to ERROR.
  - Match: continue as normal.
  - The timeout applies to the read too.
- Undefined: no reads are issued; wbm_data_i is unused; the RD and CHK states are not present.

Decomposition:
- Shared header fabric_cfg_defs: BASE_ADDR, CTRL_OFFSET, COL_STRIDE, NUM_COLS and the state encodings. The same header is used by the configuration responder.
- One sub-module, wb_ack_timer: clear/enable inputs, timeout pulse output, TIMEOUT_CYCLES parameter.

Test Plan:
- Three beats (col 0,1,2; data 0xA5A5_0001/2/3; last on the third), responder acks after 1 cycle -> writes go to 0x3000_0000, _0004, _0008 then commit to _0010 with data 1; done=1; word_count=3.
- s_valid held low for 10 cycles mid-stream -> s_ready stays 1; no bus activity; load completes once beats resume.
- Beat with s_col=3 -> no cyc asserted; err=1; done=0; word_count unchanged.
- Responder never acks -> cyc drops exactly TIMEOUT_CYCLES+1 cycles after stb rises; err=1; next start clears err and the load succeeds.
- wb_rst_i asserted during WR -> all outputs 0 next cycle; no commit write.
- With LOADER_READBACK_VERIFY_EN, responder returns 0xDEAD_BEEF for a written 0x1234_5678 -> err=1 after the read; no commit.
